vga_timing_compositor: RTL and testbench
========================================

Name: vga_timing_compositor

Overview:
- Upstream and downstream neighbour of the sprite unit.
- Generates 1024x768@60 XGA raster timing (pix_x, pix_y, video_active, vsync) that drives fluid_sprite.
- Consumes sprite_pixel_on and emits delay-aligned hsync_n, vsync_n and a registered 6-bit RRGGBB pixel to the VGA pins.
- Also provides a frame counter and a line-start strobe for the host.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- PIPE_DLY, 1, clocks from pix_x/pix_y to a valid sprite_pixel_on (range 1..4)

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = raster runs; 0 = counters held at 0, syncs inactive
- fg_color  in  6  RRGGBB colour used where sprite_pixel_on = 1
- bg_color  in  6  RRGGBB colour used for active pixels with no sprite
- sprite_pixel_on  in  1  from the sprite unit, valid PIPE_DLY clocks after pix_x/pix_y
- pix_x  out  10  current column 0..1023; 0 outside the active area
- pix_y  out  10  current line 0..767; 0 outside the active area
- video_active  out  1  1 when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE (undelayed)
- vsync  out  1  active-high, undelayed, 1 during vertical sync lines; feeds the sprite unit
- hsync_n  out  1  VGA hsync, active-low, delayed PIPE_DLY+1
- vsync_n  out  1  VGA vsync, active-low, delayed PIPE_DLY+1
- rgb  out  6  VGA colour, delayed PIPE_DLY+1
- line_start  out  1  1-cycle pulse when h_cnt = 0 and enable = 1
- frame_count  out  8  increments at each frame wrap; wraps 255 -> 0

Behaviour:
- Counters:
  - Internal h_cnt is 11 bits, range 0..H_TOTAL-1 (H_TOTAL = 1344).
  - Internal v_cnt is 10 bits, range 0..V_TOTAL-1 (V_TOTAL = 806).
  - h_cnt increments every clock while enable = 1.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At h_cnt = H_TOTAL-1 with v_cnt = V_TOTAL-1, both wrap to 0 and frame_count increments in the same cycle.
- Reset:
  - Asynchronous on rst_n low. h_cnt, v_cnt and frame_count go to 0.
  - hsync_n = 1, vsync_n = 1, vsync = 0, rgb = 0, line_start = 0, video_active = 0, pix_x = pix_y = 0.
  - All delay-pipeline stages are cleared to the inactive values.
  - Reset mid-frame restarts at pixel (0,0) after rst_n rises; there is no partial-frame recovery.
- enable = 0:
  - Next clock, h_cnt and v_cnt go to 0; frame_count holds.
  - Raw syncs are inactive, video_active = 0 and line_start = 0.
  - The pipeline keeps shifting, so rgb reaches 0 and syncs go high PIPE_DLY+1 clocks later.
  - enable re-asserted: the raster restarts from (0,0).
- Raw sync decode (combinational from counters):
  - hsync_raw = 1 for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
  - vsync_raw = 1 for lines 771..776.
  - The vsync output is vsync_raw registered with zero extra delay relative to pix_y. The sprite unit rising-edge-detects it once per frame.
- pix_x, pix_y, video_active: derived from the counters in the same cycle; they are the pipeline reference point (stage 0).
- Alignment pipeline:
  - video_active, hsync_raw and vsync_raw pass through a PIPE_DLY-deep shift register.
  - At stage PIPE_DLY, combine: colour = active_d ? (sprite_pixel_on ? fg_color : bg_color) : 6'b0.
  - colour is registered into rgb, together with ~hsync_d -> hsync_n and ~vsync_d -> vsync_n.
  - All three VGA outputs change on the same edge.
  - Total latency from pix_x to rgb is PIPE_DLY+1 clocks.
- fg_color and bg_color are sampled at the combine stage with no synchronisation; a change mid-line takes effect on the next pixel.
- sprite_pixel_on is ignored (rgb = 0) whenever the delayed active flag is 0, even if it is 1.

Decomposition:
- Shared package vga_timing_pkg holds:
  - XGA localparams H_ACTIVE, H_FP, H_SYNC, H_BP, V_*.
  - Derived H_TOTAL and V_TOTAL.
  - The RRGGBB colour width constant COLOR_W = 6.
- One sub-module is natural: vga_delay_line (parameterised width and depth shift register with async reset value). It is instantiated once for {active, hsync, vsync}.

Test Plan:
- Reset release then 1344 clocks -> pix_x runs 0..1023, then 0; line_start pulses at clocks 0 and 1344; hsync_n low for exactly 136 clocks starting 1048+PIPE_DLY+1 clocks after reset release.
- Run one full frame (1344*806 clocks) -> vsync high for exactly 6*1344 clocks starting at line 771; vsync_n mirrors it inverted, delayed 2 clocks; frame_count = 1 at wrap.
- PIPE_DLY=1, sprite_pixel_on = 1 only on the cycle after pix_x = 100, pix_y = 50; fg = 6'h3F, bg = 6'h01 -> rgb = 6'h3F for exactly one clock, 2 clocks after pix_x = 100; 6'h01 on neighbouring active pixels; 6'h00 in blanking.
- sprite_pixel_on held at 1 during horizontal blanking -> rgb stays 6'h00.
- Drop enable at pix_x = 500 on line 10 for 5 clocks, then raise -> h_cnt/v_cnt return to 0 and the raster restarts at (0,0); frame_count unchanged; rgb = 0 within 2 clocks.
- Assert rst_n low mid-line 400 asynchronously (off clock edge) -> all outputs at reset values immediately; after release, the first line_start arrives at the first enabled clock; 256 frames later frame_count wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared XGA 1024x768@60 timing constants and pipeline flag type
// for the raster compositor and its delay line.
package vga_timing_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int COLOR_W  = 6;

  // Flags that travel through the alignment pipeline alongside the sprite lookup.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_flags_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with an asynchronous reset value, used to
// align raster flags with the sprite unit's latency.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_compositor.sv
// XGA raster generator that feeds the sprite unit and drives the VGA pins
// with syncs and colour aligned to the sprite unit's PIPE_DLY latency.
module vga_timing_compositor
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int PIPE_DLY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               sprite_pixel_on,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic               video_active,
  output logic               vsync,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic [COLOR_W-1:0] rgb,
  output logic               line_start,
  output logic [7:0]         frame_count
);

  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT_W  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0]        h_cnt_q, h_cnt_d;
  logic [9:0]         v_cnt_q, v_cnt_d;
  logic [7:0]         frame_q, frame_d;
  logic [COLOR_W-1:0] rgb_q, colour_d;
  logic               hsync_n_q, vsync_n_q;
  logic               live;
  sync_flags_t        flags_s0, flags_dly;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    frame_d = frame_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
        frame_d = frame_q + 8'd1;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
      end
    end else begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      frame_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      frame_q <= frame_d;
    end
  end

  // Stage-0 decode is gated so that reset and disable force every raw flag inactive.
  assign live           = enable & rst_n;
  assign flags_s0.active = live && (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
  assign flags_s0.hsync  = live && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign flags_s0.vsync  = live && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

  assign pix_x        = flags_s0.active ? h_cnt_q[9:0] : '0;
  assign pix_y        = flags_s0.active ? v_cnt_q : '0;
  assign video_active = flags_s0.active;
  assign vsync        = flags_s0.vsync;
  assign line_start   = live && (h_cnt_q == '0);
  assign frame_count  = frame_q;

  vga_delay_line #(
    .WIDTH     ($bits(sync_flags_t)),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL ('0)
  ) u_flag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (flags_s0),
    .q_o   (flags_dly)
  );

  assign colour_d = flags_dly.active ? (sprite_pixel_on ? fg_color : bg_color) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      rgb_q     <= colour_d;
      hsync_n_q <= ~flags_dly.hsync;
      vsync_n_q <= ~flags_dly.vsync;
    end
  end

  assign rgb     = rgb_q;
  assign hsync_n = hsync_n_q;
  assign vsync_n = vsync_n_q;

endmodule

// File: tb/tb_vga_timing_compositor.sv
// Directed bench: full-size XGA instance for line/sprite/enable checks and a
// shrunken-timing instance for frame-level vsync and frame_count wrap checks.
module tb_vga_timing_compositor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [5:0] fg, bg;
  logic       spr;

  logic [9:0] x_px, x_py, s_px, s_py;
  logic       x_act, x_vs, x_hsn, x_vsn, x_ls;
  logic       s_act, s_vs, s_hsn, s_vsn, s_ls;
  logic [5:0] x_rgb, s_rgb;
  logic [7:0] x_fc, s_fc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int phase = 0;
  int hsLow, hsFirst, lsCount, svHigh, svFirst, svnLow, svnFirst, nzCount;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       ls;
    logic       hsn;
    logic [5:0] rgb;
  } vec_t;

  vec_t vecs [15];

  always #5 clk = ~clk;

  vga_timing_compositor #(.PIPE_DLY(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fg_color(fg), .bg_color(bg),
    .sprite_pixel_on(spr), .pix_x(x_px), .pix_y(x_py), .video_active(x_act),
    .vsync(x_vs), .hsync_n(x_hsn), .vsync_n(x_vsn), .rgb(x_rgb),
    .line_start(x_ls), .frame_count(x_fc)
  );

  // 25 clocks x 10 lines: vsync on lines 7..8, 250 clocks per frame.
  vga_timing_compositor #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DLY(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fg_color(fg), .bg_color(bg),
    .sprite_pixel_on(spr), .pix_x(s_px), .pix_y(s_py), .video_active(s_act),
    .vsync(s_vs), .hsync_n(s_hsn), .vsync_n(s_vsn), .rgb(s_rgb),
    .line_start(s_ls), .frame_count(s_fc)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (!x_hsn) begin
      if (hsLow == 0) hsFirst = cyc;
      hsLow++;
    end
    if (x_ls) lsCount++;
    if (phase == 0 && cyc < 250) begin
      if (s_vs) begin
        if (svHigh == 0) svFirst = cyc;
        svHigh++;
      end
      if (!s_vsn) begin
        if (svnLow == 0) svnFirst = cyc;
        svnLow++;
      end
    end
    if (phase == 0 && cyc == 249)   checkOutput("small_fc_before_wrap", 32'(s_fc), 32'd0);
    if (phase == 0 && cyc == 250)   checkOutput("small_fc_at_wrap", 32'(s_fc), 32'd1);
    if (phase == 2 && cyc == 50249) checkOutput("small_fc_255", 32'(s_fc), 32'd255);
    if (phase == 2 && cyc == 50250) checkOutput("small_fc_wrap0", 32'(s_fc), 32'd0);
  endtask

  task automatic walkTo(input int n);
    while (cyc < n) applyStimulus();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pix_x"}, 32'(x_px), 32'd0);
    checkOutput({tag, "_pix_y"}, 32'(x_py), 32'd0);
    checkOutput({tag, "_active"}, 32'(x_act), 32'd0);
    checkOutput({tag, "_line_start"}, 32'(x_ls), 32'd0);
    checkOutput({tag, "_vsync"}, 32'(x_vs), 32'd0);
    checkOutput({tag, "_hsync_n"}, 32'(x_hsn), 32'd1);
    checkOutput({tag, "_vsync_n"}, 32'(x_vsn), 32'd1);
    checkOutput({tag, "_rgb"}, 32'(x_rgb), 32'd0);
    checkOutput({tag, "_fc"}, 32'(x_fc), 32'd0);
    checkOutput({tag, "_small_fc"}, 32'(s_fc), 32'd0);
  endtask

  initial begin
    //            cyc   x        y      act   ls    hsn   rgb
    vecs[0]  = '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 6'h00};
    vecs[1]  = '{1,    10'd1,   10'd0, 1'b1, 1'b0, 1'b1, 6'h00};
    vecs[2]  = '{2,    10'd2,   10'd0, 1'b1, 1'b0, 1'b1, 6'h01};
    vecs[3]  = '{500,  10'd500, 10'd0, 1'b1, 1'b0, 1'b1, 6'h01};
    vecs[4]  = '{1023, 10'd1023,10'd0, 1'b1, 1'b0, 1'b1, 6'h01};
    vecs[5]  = '{1024, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1, 6'h01};
    vecs[6]  = '{1025, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1, 6'h01};
    vecs[7]  = '{1026, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1, 6'h00};
    vecs[8]  = '{1049, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1, 6'h00};
    vecs[9]  = '{1050, 10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 6'h00};
    vecs[10] = '{1185, 10'd0,   10'd0, 1'b0, 1'b0, 1'b0, 6'h00};
    vecs[11] = '{1186, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1, 6'h00};
    vecs[12] = '{1343, 10'd0,   10'd0, 1'b0, 1'b0, 1'b1, 6'h00};
    vecs[13] = '{1344, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 6'h00};
    vecs[14] = '{1346, 10'd2,   10'd1, 1'b1, 1'b0, 1'b1, 6'h01};

    rst_n = 1'b1; enable = 1'b1; fg = 6'h3F; bg = 6'h01; spr = 1'b0;
    hsLow = 0; hsFirst = -1; svHigh = 0; svFirst = -1; svnLow = 0; svnFirst = -1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");

    // Phase 0: first XGA line from the table, first small frame in the background.
    rst_n = 1'b1;
    cyc = 0;
    #1;
    lsCount = x_ls ? 1 : 0;
    for (int i = 0; i < 15; i++) begin
      walkTo(vecs[i].cyc);
      if (i == 0) #0;
      checkOutput($sformatf("v%0d_pix_x", i), 32'(x_px), 32'(vecs[i].x));
      checkOutput($sformatf("v%0d_pix_y", i), 32'(x_py), 32'(vecs[i].y));
      checkOutput($sformatf("v%0d_active", i), 32'(x_act), 32'(vecs[i].act));
      checkOutput($sformatf("v%0d_line_start", i), 32'(x_ls), 32'(vecs[i].ls));
      checkOutput($sformatf("v%0d_hsync_n", i), 32'(x_hsn), 32'(vecs[i].hsn));
      checkOutput($sformatf("v%0d_rgb", i), 32'(x_rgb), 32'(vecs[i].rgb));
    end
    checkOutput("hsync_low_count", 32'(hsLow), 32'd136);
    checkOutput("hsync_first_low", 32'(hsFirst), 32'd1050);
    checkOutput("line_start_count", 32'(lsCount), 32'd2);
    checkOutput("small_vsync_count", 32'(svHigh), 32'd50);
    checkOutput("small_vsync_first", 32'(svFirst), 32'd175);
    checkOutput("small_vsync_n_count", 32'(svnLow), 32'd50);
    checkOutput("small_vsync_n_first", 32'(svnFirst), 32'd177);

    // Asynchronous reset in the middle of line 1 at column 400.
    walkTo(1744);
    checkOutput("pre_reset_pix_x", 32'(x_px), 32'd400);
    checkOutput("pre_reset_pix_y", 32'(x_py), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetState("midreset");
    @(posedge clk);
    @(negedge clk);
    checkResetState("midreset_held");

    // Phase 1: restart from (0,0), then drop enable at line 10 column 500.
    phase = 1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
    checkOutput("restart_line_start", 32'(x_ls), 32'd1);
    checkOutput("restart_pix_x", 32'(x_px), 32'd0);
    walkTo(13940);
    checkOutput("pre_drop_pix_x", 32'(x_px), 32'd500);
    checkOutput("pre_drop_pix_y", 32'(x_py), 32'd10);
    enable = 1'b0;
    #1;
    checkOutput("drop_active", 32'(x_act), 32'd0);
    checkOutput("drop_pix_x", 32'(x_px), 32'd0);
    walkTo(13941);
    checkOutput("drop_rgb_1clk", 32'(x_rgb), 32'h01);
    walkTo(13942);
    checkOutput("drop_rgb_2clk", 32'(x_rgb), 32'h00);
    walkTo(13945);
    checkOutput("drop_rgb_held", 32'(x_rgb), 32'h00);
    checkOutput("drop_hsync_n", 32'(x_hsn), 32'd1);
    checkOutput("drop_line_start", 32'(x_ls), 32'd0);
    checkOutput("drop_fc", 32'(x_fc), 32'd0);
    checkOutput("drop_small_fc", 32'(s_fc), 32'd55);

    // Phase 2: re-enable; sprite at (100,50), then a blanking sweep with the sprite held on.
    phase = 2;
    enable = 1'b1;
    cyc = 0;
    #1;
    checkOutput("reen_line_start", 32'(x_ls), 32'd1);
    checkOutput("reen_active", 32'(x_act), 32'd1);
    checkOutput("reen_pix_y", 32'(x_py), 32'd0);
    walkTo(1);
    checkOutput("reen_pix_x1", 32'(x_px), 32'd1);
    checkOutput("reen_small_fc", 32'(s_fc), 32'd55);
    walkTo(2);
    checkOutput("reen_rgb_bg", 32'(x_rgb), 32'h01);

    walkTo(67300);
    checkOutput("spr_pix_x", 32'(x_px), 32'd100);
    checkOutput("spr_pix_y", 32'(x_py), 32'd50);
    walkTo(67301);
    spr = 1'b1;
    checkOutput("spr_rgb_before", 32'(x_rgb), 32'h01);
    walkTo(67302);
    spr = 1'b0;
    checkOutput("spr_rgb_hit", 32'(x_rgb), 32'h3F);
    walkTo(67303);
    checkOutput("spr_rgb_after", 32'(x_rgb), 32'h01);
    walkTo(67310);
    bg = 6'h2A;
    walkTo(67311);
    bg = 6'h01;
    checkOutput("bg_change_rgb", 32'(x_rgb), 32'h2A);
    walkTo(67312);
    checkOutput("bg_restore_rgb", 32'(x_rgb), 32'h01);

    walkTo(68225);
    spr = 1'b1;
    nzCount = 0;
    while (cyc < 68545) begin
      applyStimulus();
      if (x_rgb != 6'h00) nzCount++;
    end
    spr = 1'b0;
    checkOutput("blank_sprite_nonzero", 32'(nzCount), 32'd0);
    walkTo(68546);
    checkOutput("next_line_rgb", 32'(x_rgb), 32'h01);
    checkOutput("next_line_pix_y", 32'(x_py), 32'd51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
